// File: rtl/d_fifo_reader.sv
// d_fifo_reader: egress reader for destination FIFOs D0/D1.
// Pops with round-robin arbitration, registers the popped word with its
// destination index, honours downstream pause and counts delivered words.
module d_fifo_reader #(
  parameter int BW    = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  input  logic             egress_pause,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic             egress_valid,
  output logic [BW-1:0]    egress_data,
  output logic             egress_dest,
  output logic [CNT_W-1:0] D0_count,
  output logic [CNT_W-1:0] D1_count,
  output logic             idle
);

  logic             w_d0Ready;
  logic             w_d1Ready;
  logic             w_d0Rd;
  logic             w_d1Rd;
  logic             w_anyRd;
  logic [BW-1:0]    w_inflightData;

  logic             r_lastGrant;
  logic             r_inflight;
  logic             r_inflightDest;
  logic             r_egressValid;
  logic [BW-1:0]    r_egressData;
  logic             r_egressDest;
  logic [CNT_W-1:0] r_d0Count;
  logic [CNT_W-1:0] r_d1Count;
  logic             r_idle;

  assign w_d0Ready = ~D0_empty;
  assign w_d1Ready = ~D1_empty;

  // Pop decision: reset and pause block all pops; a tie goes to the FIFO not served last.
  always_comb begin
    w_d0Rd = 1'b0;
    w_d1Rd = 1'b0;
    if (reset_L && !egress_pause) begin
      if (w_d0Ready && w_d1Ready) begin
        if (r_lastGrant) begin
          w_d0Rd = 1'b1;
        end else begin
          w_d1Rd = 1'b1;
        end
      end else if (w_d0Ready) begin
        w_d0Rd = 1'b1;
      end else if (w_d1Ready) begin
        w_d1Rd = 1'b1;
      end
    end
  end

  assign w_anyRd        = w_d0Rd | w_d1Rd;
  assign w_inflightData = r_inflightDest ? D1_data_out : D0_data_out;

  // Track the last grant and the pop whose data arrives on the next cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_lastGrant    <= 1'b1;
      r_inflight     <= 1'b0;
      r_inflightDest <= 1'b0;
    end else if (w_anyRd) begin
      r_lastGrant    <= w_d1Rd;
      r_inflight     <= 1'b1;
      r_inflightDest <= w_d1Rd;
    end else begin
      r_inflight     <= 1'b0;
    end
  end

  // Capture the in-flight word onto the egress port; data/dest hold when nothing arrives.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_egressValid <= 1'b0;
      r_egressData  <= '0;
      r_egressDest  <= 1'b0;
    end else if (r_inflight) begin
      r_egressValid <= 1'b1;
      r_egressData  <= w_inflightData;
      r_egressDest  <= r_inflightDest;
    end else begin
      r_egressValid <= 1'b0;
    end
  end

  // Count delivered words per destination; overflow wraps silently.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_d0Count <= '0;
      r_d1Count <= '0;
    end else if (r_inflight) begin
      if (r_inflightDest) begin
        r_d1Count <= r_d1Count + CNT_W'(1);
      end else begin
        r_d0Count <= r_d0Count + CNT_W'(1);
      end
    end
  end

  // Idle when both FIFOs are empty, nothing is being popped and nothing is in flight.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_idle <= 1'b1;
    end else begin
      r_idle <= D0_empty & D1_empty & ~w_anyRd & ~r_inflight;
    end
  end

  assign D0_rd        = w_d0Rd;
  assign D1_rd        = w_d1Rd;
  assign egress_valid = r_egressValid;
  assign egress_data  = r_egressData;
  assign egress_dest  = r_egressDest;
  assign D0_count     = r_d0Count;
  assign D1_count     = r_d1Count;
  assign idle         = r_idle;

endmodule

// File: tb/tb_d_fifo_reader.sv
// Directed bench for d_fifo_reader with a behavioural model of the two FIFOs.
module tb_d_fifo_reader;

  logic       clk;
  logic       reset_L;
  logic       D0_empty;
  logic       D1_empty;
  logic [5:0] D0_data_out;
  logic [5:0] D1_data_out;
  logic       egress_pause;
  logic       D0_rd;
  logic       D1_rd;
  logic       egress_valid;
  logic [5:0] egress_data;
  logic       egress_dest;
  logic [7:0] D0_count;
  logic [7:0] D1_count;
  logic       idle;

  logic       w2D0Rd;
  logic       w2D1Rd;
  logic       w2Valid;
  logic [5:0] w2Data;
  logic       w2Dest;
  logic [1:0] w2D0Count;
  logic [1:0] w2D1Count;
  logic       w2Idle;

  logic [5:0] q0[$];
  logic [5:0] q1[$];

  int testCount = 0;
  int failCount = 0;

  d_fifo_reader #(.BW(6), .CNT_W(8)) dut (
    .clk(clk), .reset_L(reset_L),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .egress_pause(egress_pause),
    .D0_rd(D0_rd), .D1_rd(D1_rd),
    .egress_valid(egress_valid), .egress_data(egress_data), .egress_dest(egress_dest),
    .D0_count(D0_count), .D1_count(D1_count), .idle(idle)
  );

  // Narrow-counter instance sharing the same FIFO stimulus, used for wrap checks.
  d_fifo_reader #(.BW(6), .CNT_W(2)) dutWrap (
    .clk(clk), .reset_L(reset_L),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .egress_pause(egress_pause),
    .D0_rd(w2D0Rd), .D1_rd(w2D1Rd),
    .egress_valid(w2Valid), .egress_data(w2Data), .egress_dest(w2Dest),
    .D0_count(w2D0Count), .D1_count(w2D1Count), .idle(w2Idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRd(input string tag, input logic e0, input logic e1);
    checkOutput({tag, " D0_rd"}, {31'b0, D0_rd}, {31'b0, e0});
    checkOutput({tag, " D1_rd"}, {31'b0, D1_rd}, {31'b0, e1});
  endtask

  task automatic checkEgress(input string tag, input logic v, input logic [5:0] d, input logic dst);
    checkOutput({tag, " valid"}, {31'b0, egress_valid}, {31'b0, v});
    if (v) begin
      checkOutput({tag, " data"}, {26'b0, egress_data}, {26'b0, d});
      checkOutput({tag, " dest"}, {31'b0, egress_dest}, {31'b0, dst});
    end
  endtask

  task automatic push0(input logic [5:0] v);
    q0.push_back(v);
    D0_empty <= 1'b0;
  endtask

  task automatic push1(input logic [5:0] v);
    q1.push_back(v);
    D1_empty <= 1'b0;
  endtask

  // One clock: the FIFO model pops on the rising edge if rd was high, then settle after the falling edge.
  task automatic applyStimulus();
    logic p0;
    logic p1;
    p0 = D0_rd;
    p1 = D1_rd;
    @(posedge clk);
    if (p0) begin
      D0_data_out <= q0.pop_front();
      D0_empty    <= (q0.size() == 0);
    end
    if (p1) begin
      D1_data_out <= q1.pop_front();
      D1_empty    <= (q1.size() == 0);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset_L = 1'b0;
    #1;
    applyStimulus();
    reset_L = 1'b1;
    #1;
  endtask

  initial begin
    reset_L      = 1'b0;
    egress_pause = 1'b0;
    D0_empty     = 1'b1;
    D1_empty     = 1'b1;
    D0_data_out  = '0;
    D1_data_out  = '0;

    // Reset held for two cycles with both FIFOs empty.
    @(negedge clk);
    #1;
    applyStimulus();
    applyStimulus();
    checkEgress("rst", 1'b0, 6'h00, 1'b0);
    checkOutput("rst data", {26'b0, egress_data}, 32'h0);
    checkOutput("rst dest", {31'b0, egress_dest}, 32'h0);
    checkOutput("rst D0_count", {24'b0, D0_count}, 32'h0);
    checkOutput("rst D1_count", {24'b0, D1_count}, 32'h0);
    checkOutput("rst idle", {31'b0, idle}, 32'h1);
    checkRd("rst", 1'b0, 1'b0);
    reset_L = 1'b1;
    #1;

    // Single source: three words from D0 only.
    push0(6'h05); push0(6'h2A); push0(6'h3F);
    #1;
    checkRd("single c0", 1'b1, 1'b0);
    checkEgress("single c0", 1'b0, 6'h00, 1'b0);
    applyStimulus();
    checkRd("single c1", 1'b1, 1'b0);
    checkEgress("single c1", 1'b0, 6'h00, 1'b0);
    applyStimulus();
    checkRd("single c2", 1'b1, 1'b0);
    checkEgress("single c2", 1'b1, 6'h05, 1'b0);
    applyStimulus();
    checkRd("single c3", 1'b0, 1'b0);
    checkEgress("single c3", 1'b1, 6'h2A, 1'b0);
    applyStimulus();
    checkEgress("single c4", 1'b1, 6'h3F, 1'b0);
    checkOutput("single D0_count", {24'b0, D0_count}, 32'd3);
    checkOutput("single idle c4", {31'b0, idle}, 32'h0);
    applyStimulus();
    checkEgress("single c5", 1'b0, 6'h00, 1'b0);
    checkOutput("single hold data", {26'b0, egress_data}, 32'h3F);
    checkOutput("single idle c5", {31'b0, idle}, 32'h1);

    // Round-robin tie from reset: D0 wins first, then strict alternation.
    applyReset();
    checkOutput("rr D0_count rst", {24'b0, D0_count}, 32'h0);
    push0(6'h01); push0(6'h02); push1(6'h11); push1(6'h12);
    #1;
    checkRd("rr c0", 1'b1, 1'b0);
    applyStimulus();
    checkRd("rr c1", 1'b0, 1'b1);
    applyStimulus();
    checkRd("rr c2", 1'b1, 1'b0);
    checkEgress("rr c2", 1'b1, 6'h01, 1'b0);
    applyStimulus();
    checkRd("rr c3", 1'b0, 1'b1);
    checkEgress("rr c3", 1'b1, 6'h11, 1'b1);
    applyStimulus();
    checkRd("rr c4", 1'b0, 1'b0);
    checkEgress("rr c4", 1'b1, 6'h02, 1'b0);
    applyStimulus();
    checkEgress("rr c5", 1'b1, 6'h12, 1'b1);
    checkOutput("rr D0_count", {24'b0, D0_count}, 32'd2);
    checkOutput("rr D1_count", {24'b0, D1_count}, 32'd2);

    // Pause raised right after a D1 pop: the in-flight word still lands, no pops while paused.
    push1(6'h21);
    #1;
    checkRd("pause c0", 1'b0, 1'b1);
    applyStimulus();
    egress_pause = 1'b1;
    push0(6'h31); push1(6'h22);
    #1;
    checkRd("pause c1", 1'b0, 1'b0);
    checkEgress("pause c1", 1'b0, 6'h00, 1'b0);
    applyStimulus();
    checkRd("pause c2", 1'b0, 1'b0);
    checkEgress("pause c2", 1'b1, 6'h21, 1'b1);
    applyStimulus();
    checkRd("pause c3", 1'b0, 1'b0);
    checkEgress("pause c3", 1'b0, 6'h00, 1'b0);
    egress_pause = 1'b0;
    #1;
    checkRd("resume c3", 1'b1, 1'b0);
    applyStimulus();
    checkRd("resume c4", 1'b0, 1'b1);
    applyStimulus();
    checkRd("resume c5", 1'b0, 1'b0);
    checkEgress("resume c5", 1'b1, 6'h31, 1'b0);
    applyStimulus();
    checkEgress("resume c6", 1'b1, 6'h22, 1'b1);
    checkOutput("pause D0_count", {24'b0, D0_count}, 32'd3);
    checkOutput("pause D1_count", {24'b0, D1_count}, 32'd4);

    // Reset dropped the cycle after a D0 pop: in-flight word is discarded.
    push0(6'h0A);
    #1;
    checkRd("mid c0", 1'b1, 1'b0);
    applyStimulus();
    reset_L = 1'b0;
    #1;
    checkEgress("mid rst", 1'b0, 6'h00, 1'b0);
    checkOutput("mid rst D0_count", {24'b0, D0_count}, 32'h0);
    checkOutput("mid rst D1_count", {24'b0, D1_count}, 32'h0);
    checkOutput("mid rst idle", {31'b0, idle}, 32'h1);
    push0(6'h0B); push1(6'h15);
    #1;
    checkRd("mid rst held", 1'b0, 1'b0);
    applyStimulus();
    checkEgress("mid discard", 1'b0, 6'h00, 1'b0);
    checkOutput("mid discard data", {26'b0, egress_data}, 32'h0);
    reset_L = 1'b1;
    #1;
    checkRd("mid rel c0", 1'b1, 1'b0);
    applyStimulus();
    checkRd("mid rel c1", 1'b0, 1'b1);
    applyStimulus();
    checkEgress("mid rel c2", 1'b1, 6'h0B, 1'b0);
    applyStimulus();
    checkEgress("mid rel c3", 1'b1, 6'h15, 1'b1);
    checkOutput("mid D0_count", {24'b0, D0_count}, 32'd1);
    checkOutput("mid D1_count", {24'b0, D1_count}, 32'd1);
    applyStimulus();
    checkOutput("mid idle", {31'b0, idle}, 32'h1);

    // Counter wrap on the 2-bit instance: five D0 words leave D0_count at 1.
    applyReset();
    for (int i = 1; i <= 5; i++) begin
      push0(6'(i));
    end
    #1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
    end
    checkOutput("wrap D0_count", {30'b0, w2D0Count}, 32'd1);
    checkOutput("wrap D1_count", {30'b0, w2D1Count}, 32'd0);
    checkOutput("wide D0_count", {24'b0, D0_count}, 32'd5);
    checkOutput("wrap idle", {31'b0, w2Idle}, 32'h1);
    checkEgress("wrap last", 1'b0, 6'h00, 1'b0);
    checkOutput("wrap last data", {26'b0, w2Data}, 32'h05);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
